// File: rtl/serial_encoder_pkg.sv
// serial_encoder_pkg
//   Shared constants for the 8b10b transmit path. It holds the comma symbols
//   in their RD- form, the RD- code tables for the 5b/6b and 3b/4b
//   sub-blocks, and the controller state encoding.
//   Optional feature macro used by the top: SERIAL_ENCODER_RESYNC_EN.
package serial_encoder_pkg;

  localparam logic [9:0] K_28_5_RDN  = 10'b0011111010;
  localparam logic [9:0] K_28_7_RDN  = 10'b0011111000;
  localparam logic [7:0] K_28_5_BYTE = 8'hBC;
  localparam logic [7:0] K_28_7_BYTE = 8'hFC;

  // abcdei, index = EDCBA
  localparam logic [5:0] TBL_5B6B_RDN [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  // fghj, index = HGF; entry 7 is the primary P7 form
  localparam logic [3:0] TBL_3B4B_RDN [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  localparam logic [3:0] A7_RDN = 4'b0111;

  typedef logic [0:0] state_t;
  localparam state_t ST_SYNC = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/serial_encoder_encode.sv
// encode_8b10b
//   Combinational 8b10b encoder with running-disparity tracking.
//   Ports:
//     data   in  8   byte, HGF EDCBA = data[7:5], data[4:0]
//     is_k   in  1   control symbol; 8'hFC gives K.28.7, any other value K.28.5
//     rd_in  in  1   running disparity before the symbol (1 = RD+)
//     sym    out 10  encoded symbol, bit 9 = a ... bit 0 = j
//     rd_out out 1   running disparity after the symbol
module encode_8b10b
  import serial_encoder_pkg::*;
(
  input  logic [7:0] data,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] sym,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] t6, s6;
  logic [3:0] t4, s4;
  logic       unbal6, unbal4, rd_mid, use_a7;
  logic [9:0] k_sym;

  assign x = data[4:0];
  assign y = data[7:5];

  always_comb begin
    t6     = TBL_5B6B_RDN[x];
    unbal6 = ($countones(t6) != 3);
    // D.7 is balanced but still has distinct RD- / RD+ forms
    s6     = (rd_in && (unbal6 || x == 5'd7)) ? ~t6 : t6;
    rd_mid = rd_in ^ unbal6;

    // A7 avoids a run of five equal bits across the sub-block boundary
    use_a7 = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
             ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    if (y == 3'd7) t4 = use_a7 ? A7_RDN : TBL_3B4B_RDN[7];
    else           t4 = TBL_3B4B_RDN[y];
    unbal4 = ($countones(t4) != 2);
    // x.3 is balanced but still has distinct RD- / RD+ forms
    s4     = (rd_mid && (unbal4 || y == 3'd3)) ? ~t4 : t4;

    k_sym = (data == K_28_7_BYTE) ? K_28_7_RDN : K_28_5_RDN;

    if (is_k) begin
      sym    = rd_in ? ~k_sym : k_sym;
      rd_out = rd_in ^ ($countones(k_sym) != 5);
    end else begin
      sym    = {s6, s4};
      rd_out = rd_mid ^ unbal4;
    end
  end

endmodule

// File: rtl/serial_encoder.sv
// serial_encoder
//   8b10b encoder and serializer, one line bit per clk, bit 9 of each symbol first.
//   After reset it sends SYNC_COUNT K.28.5 commas. It then sends the held
//   data byte when one is present, and K.28.7 filler otherwise.
//   Ports:
//     clk        in  1  clock, posedge
//     rst        in  1  asynchronous active-high reset
//     data_in    in  8  byte to send
//     data_valid in  1  data_in valid
//     data_ready out 1  hold register empty
//     serial_out out 1  registered serial line
//     sym_start  out 1  serial_out carries bit 9 of a symbol
//     rd_pos     out 1  running disparity after the symbol on the line
//   Optional: define SERIAL_ENCODER_RESYNC_EN to insert a K.28.5 pair every
//   RESYNC_PERIOD symbols while running.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_SYNC | sending initial K.28.5 commas, hold is not drained
//   ST_RUN  | sending held data, or K.28.7 filler when hold empty
module serial_encoder
  import serial_encoder_pkg::*;
#(
  parameter int SYNC_COUNT    = 2,
  parameter int RESYNC_PERIOD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_out,
  output logic       sym_start,
  output logic       rd_pos
);

  localparam int SYNC_W = $clog2(SYNC_COUNT + 1);

  if (SYNC_COUNT < 1 || RESYNC_PERIOD < 1) begin : g_param_check
    $error("serial_encoder: SYNC_COUNT and RESYNC_PERIOD must be >= 1");
  end

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic [9:0]        shift_reg;
  logic [7:0]        hold_data;
  logic              hold_full;
  logic              load, accept, send_comma, send_data, resync_due;
  logic [7:0]        enc_byte;
  logic              enc_is_k, enc_rd;
  logic [9:0]        enc_sym;

  assign load       = (bit_cnt == 4'd9);
  assign data_ready = ~hold_full;
  assign accept     = data_valid && !hold_full;
  assign send_comma = (state == ST_SYNC) || resync_due;
  assign send_data  = !send_comma && hold_full;

`ifdef SERIAL_ENCODER_RESYNC_EN
  localparam int RS_W = $clog2(RESYNC_PERIOD + 1);

  logic [RS_W-1:0] rs_left;
  logic            rs_second;

  // rs_left counts RUN symbols down to the next comma pair; rs_second marks
  // that the first comma of the pair has gone out.
  assign resync_due = rs_second || (rs_left == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_left   <= RS_W'(RESYNC_PERIOD);
      rs_second <= 1'b0;
    end else if (load && state == ST_RUN) begin
      if (rs_second) begin
        rs_second <= 1'b0;
        rs_left   <= RS_W'(RESYNC_PERIOD);
      end else if (rs_left == '0) begin
        rs_second <= 1'b1;
      end else begin
        rs_left <= rs_left - RS_W'(1);
      end
    end
  end
`else
  assign resync_due = 1'b0;
`endif

  always_comb begin
    enc_is_k = 1'b1;
    enc_byte = K_28_7_BYTE;
    if (send_comma) begin
      enc_byte = K_28_5_BYTE;
    end else if (hold_full) begin
      enc_is_k = 1'b0;
      enc_byte = hold_data;
    end
  end

  encode_8b10b u_encode (
    .data   (enc_byte),
    .is_k   (enc_is_k),
    .rd_in  (rd_pos),
    .sym    (enc_sym),
    .rd_out (enc_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      sync_cnt   <= '0;
      bit_cnt    <= 4'd9;
      shift_reg  <= '0;
      serial_out <= 1'b0;
      sym_start  <= 1'b0;
      rd_pos     <= 1'b0;
    end else if (load) begin
      // bit 9 goes straight to the line; the rest waits in the shifter
      serial_out <= enc_sym[9];
      shift_reg  <= {enc_sym[8:0], 1'b0};
      sym_start  <= 1'b1;
      bit_cnt    <= 4'd0;
      rd_pos     <= enc_rd;
      if (state == ST_SYNC) begin
        if (sync_cnt == SYNC_W'(SYNC_COUNT - 1)) state <= ST_RUN;
        else sync_cnt <= sync_cnt + SYNC_W'(1);
      end
    end else begin
      serial_out <= shift_reg[9];
      shift_reg  <= {shift_reg[8:0], 1'b0};
      sym_start  <= 1'b0;
      bit_cnt    <= bit_cnt + 4'd1;
    end
  end

  // accept needs an empty hold and drain needs a full one, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= data_in;
    end else if (load && send_data) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_encoder.sv
`timescale 1ns/1ps
module tb_serial_encoder;

  localparam int SYNC_COUNT    = 2;
  localparam int RESYNC_PERIOD = 4;

  localparam logic [9:0] K285_N = 10'b0011111010;
  localparam logic [9:0] K285_P = 10'b1100000101;
  localparam logic [9:0] K287_N = 10'b0011111000;
  localparam logic [9:0] K287_P = 10'b1100000111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, serial_out, sym_start, rd_pos;

  serial_encoder #(.SYNC_COUNT(SYNC_COUNT), .RESYNC_PERIOD(RESYNC_PERIOD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .serial_out (serial_out),
    .sym_start  (sym_start),
    .rd_pos     (rd_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] sym;
    logic       rd;
  } sym_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] sym;
    logic       rd_after;
  } vec_t;

  sym_t rx_q[$];
  sym_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on the DUT", name);
  endtask

  // Deserializer: symbols are framed by sym_start, sampled on negedge.
  initial begin : monitor
    logic [9:0] sh;
    int         nb;
    logic       rd_cap;
    sym_t       s;
    sh = '0;
    nb = 0;
    rd_cap = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0;
      end else begin
        if (sym_start) begin
          sh = {9'b0, serial_out};
          nb = 1;
          rd_cap = rd_pos;
        end else if (nb > 0) begin
          sh = {sh[8:0], serial_out};
          nb++;
        end
        if (nb == 10) begin
          s.sym = sh;
          s.rd  = rd_cap;
          rx_q.push_back(s);
          nb = 0;
        end
      end
    end
  end

  function automatic bit is_filler(input logic [9:0] s);
`ifdef SERIAL_ENCODER_RESYNC_EN
    return (s === K287_N) || (s === K287_P) || (s === K285_N) || (s === K285_P);
`else
    return (s === K287_N) || (s === K287_P);
`endif
  endfunction

  task automatic get_sym(output sym_t s);
    int n = 0;
    while (rx_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rx_q.size() == 0) begin
      fail_now("rx_symbol");
      s.sym = 'x;
      s.rd  = 1'bx;
    end else begin
      s = rx_q.pop_front();
    end
  endtask

  // Next symbol on the line; resync commas are tolerated when that feature is built in.
  task automatic get_next(output sym_t s);
    get_sym(s);
`ifdef SERIAL_ENCODER_RESYNC_EN
    for (int i = 0; i < 2 && (s.sym === K285_N || s.sym === K285_P); i++) get_sym(s);
`endif
  endtask

  task automatic get_data_sym(output sym_t s);
    int n = 0;
    get_sym(s);
    while (is_filler(s.sym) && n < 30) begin
      get_sym(s);
      n++;
    end
  endtask

  task automatic compare_exp(input string name, input sym_t got);
    sym_t e;
    if (exp_q.size() == 0) begin
      fail_now({name, "_scoreboard_empty"});
    end else begin
      e = exp_q.pop_front();
      check({name, "_sym"}, got.sym, e.sym);
      check({name, "_rd"}, got.rd, e.rd);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [9:0] sym, input logic rd);
    int   n = 0;
    sym_t e;
    @(negedge clk);
    while (!data_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) fail_now("send_ready");
    data_in    = b;
    data_valid = 1'b1;
    e.sym = sym;
    e.rd  = rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vt[16];
    sym_t       got;
    logic [7:0] bb[3];
    logic [9:0] bsym[3];
    logic       brd[3];
    int         n;

    // {byte, expected symbol abcdei_fghj, RD after}; chained from RD- after sync
    vt = '{
      '{8'h00, 10'b1001110100, 1'b0},
      '{8'hF1, 10'b1000110111, 1'b1},
      '{8'hEB, 10'b1101001000, 1'b0},
      '{8'h67, 10'b1110001100, 1'b0},
      '{8'h03, 10'b1100011011, 1'b1},
      '{8'h67, 10'b0001110011, 1'b1},
      '{8'hFF, 10'b0101001110, 1'b1},
      '{8'hEE, 10'b0111001000, 1'b0},
      '{8'hF4, 10'b0010110111, 1'b1},
      '{8'h55, 10'b1010100101, 1'b1},
      '{8'h10, 10'b1001001011, 1'b1},
      '{8'hBC, 10'b0011101010, 1'b1},
      '{8'h97, 10'b0001011101, 1'b1},
      '{8'h0F, 10'b1010001011, 1'b1},
      '{8'h03, 10'b1100010100, 1'b0},
      '{8'hE1, 10'b0111010001, 1'b0}
    };
    bb   = '{8'h01, 8'h02, 8'h03};
    bsym = '{10'b0111010100, 10'b1011010100, 10'b1100011011};
    brd  = '{1'b0, 1'b0, 1'b1};

    // reset state
    #12;
    check("rst_serial_out", serial_out, 1'b0);
    check("rst_sym_start", sym_start, 1'b0);
    check("rst_rd_pos", rd_pos, 1'b0);
    check("rst_data_ready", data_ready, 1'b1);

    // release: first bit on the first edge; a byte accepted during SYNC waits
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_sym_start", sym_start, 1'b1);
    check("first_bit", serial_out, 1'b0);
    send(8'h00, 10'b1001110100, 1'b0);
    get_sym(got);
    check("sync0_sym", got.sym, K285_N);
    check("sync0_rd", got.rd, 1'b1);
    get_sym(got);
    check("sync1_sym", got.sym, K285_P);
    check("sync1_rd", got.rd, 1'b0);
    get_sym(got);
    compare_exp("first_data", got);
    get_next(got);
    check("filler_sym", got.sym, K287_N);
    check("filler_rd", got.rd, 1'b0);

    // encoding table
    for (int i = 0; i < 16; i++) begin
      send(vt[i].data, vt[i].sym, vt[i].rd_after);
      get_data_sym(got);
      compare_exp($sformatf("vec%0d", i), got);
    end

    // data_valid held high across three bytes
    @(negedge clk);
    data_in    = bb[0];
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sym_t e;
      n = 0;
      while (!data_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!data_ready) fail_now("b2b_ready");
      e.sym = bsym[i];
      e.rd  = brd[i];
      exp_q.push_back(e);
      @(negedge clk);
      if (i < 2) data_in = bb[i + 1];
      else data_valid = 1'b0;
    end
    get_data_sym(got);
    compare_exp("b2b0", got);
    get_next(got);
    compare_exp("b2b1", got);
    get_next(got);
    compare_exp("b2b2", got);
    get_next(got);
    check("b2b_after_sym", got.sym, K287_P);
    check("b2b_after_rd", got.rd, 1'b1);

    // reset in mid-symbol at bit_cnt == 4 of D.21.2 (RD+, line high there)
    send(8'h55, 10'b1010100101, 1'b1);
    @(negedge clk);
    if (sym_start) @(negedge clk);
    n = 0;
    while (!sym_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sym_start) fail_now("mid_rst_sym_start");
    repeat (4) @(negedge clk);
    check("pre_rst_line", serial_out, 1'b1);
    check("pre_rst_rd_pos", rd_pos, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_serial_out", serial_out, 1'b0);
    check("mid_rst_sym_start", sym_start, 1'b0);
    check("mid_rst_rd_pos", rd_pos, 1'b0);
    check("mid_rst_data_ready", data_ready, 1'b1);
    @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_sym_start", sym_start, 1'b1);
    get_sym(got);
    check("restart0_sym", got.sym, K285_N);
    check("restart0_rd", got.rd, 1'b1);
    get_sym(got);
    check("restart1_sym", got.sym, K285_P);
    get_sym(got);
    check("restart_filler_sym", got.sym, K287_N);

`ifdef SERIAL_ENCODER_RESYNC_EN
    // idle RUN: every RESYNC_PERIOD symbols, a K.28.5 pair
    n = 0;
    get_sym(got);
    while (got.sym !== K285_N && n < 12) begin
      get_sym(got);
      n++;
    end
    check("resync_first", got.sym, K285_N);
    get_sym(got);
    check("resync_second", got.sym, K285_P);
    for (int i = 0; i < RESYNC_PERIOD; i++) begin
      get_sym(got);
      check($sformatf("resync_gap%0d", i), got.sym, K287_N);
    end
    get_sym(got);
    check("resync_next", got.sym, K285_N);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
